// File: rtl/err_pkg.sv
// Shared types and sizing helpers for the IR line-error datapath and its saturating narrow.
package err_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } err_state_t;

    // One growth bit per weight doubling plus a sign bit keeps the full sum exact.
    function automatic int acc_width(input int ir_w, input int n_pairs);
        return ir_w + n_pairs + 1;
    endfunction

    function automatic int step_width(input int n_pairs);
        return (2 * n_pairs > 2) ? $clog2(2 * n_pairs) : 1;
    endfunction

endpackage

// File: rtl/err_sat.sv
// Combinational saturating narrow of a signed value from IN_W to OUT_W bits, with a clip flag.
module err_sat #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  value_i,
    output logic signed [OUT_W-1:0] value_o,
    output logic                    sat_o
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // The value fits exactly when every bit above the output sign bit copies it.
            logic [IN_W-OUT_W:0] top_bits;
            logic                fits;

            assign top_bits = value_i[IN_W-1:OUT_W-1];
            assign fits     = (&top_bits) | ~(|top_bits);

            // NOTE: every output gets a value on every path so no latch is inferred.
            always_comb begin
                sat_o   = ~fits;
                value_o = value_i[OUT_W-1:0];
                if (!fits) begin
                    value_o = value_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                              : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_wide
            assign value_o = OUT_W'(value_i);
            assign sat_o   = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/err_compute_seq.sv
// Self-sequencing IR line-error datapath: snapshots readings, accumulates weighted differences serially, saturates.
module err_compute_seq
    import err_pkg::*;
#(
    parameter int N_PAIRS = 4,
    parameter int IR_W    = 12,
    parameter int ERR_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_PAIRS*IR_W-1:0]   IR_R,
    input  logic [N_PAIRS*IR_W-1:0]   IR_L,
    output logic signed [ERR_W-1:0]   error,
    output logic                      busy,
    output logic                      done,
    output logic                      sat
);

    localparam int ACC_W     = acc_width(IR_W, N_PAIRS);
    localparam int STEP_W    = step_width(N_PAIRS);
    localparam int LAST_STEP = 2 * N_PAIRS - 1;

    err_state_t                state_q, state_d;
    logic [N_PAIRS*IR_W-1:0]   r_snap_q, r_snap_d;
    logic [N_PAIRS*IR_W-1:0]   l_snap_q, l_snap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic signed [ERR_W-1:0]   error_q, error_d;
    logic                      sat_q, sat_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;

    int                        pair_idx;
    logic [IR_W-1:0]           reading;
    logic [ACC_W-1:0]          operand;
    logic [ACC_W-1:0]          addend;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ERR_W-1:0]   clipped;
    logic                      clipped_flag;

    // Even steps add R_i, odd steps subtract L_i via invert plus carry-in.
    always_comb begin
        pair_idx = int'(step_q >> 1);
        reading  = step_q[0] ? l_snap_q[pair_idx*IR_W +: IR_W]
                             : r_snap_q[pair_idx*IR_W +: IR_W];
        operand  = {{(ACC_W-IR_W){1'b0}}, reading} << pair_idx;
        addend   = step_q[0] ? ~operand : operand;
        acc_next = acc_q + $signed(addend) + $signed(ACC_W'(step_q[0]));
    end

    err_sat #(
        .IN_W  (ACC_W),
        .OUT_W (ERR_W)
    ) u_sat (
        .value_i (acc_q),
        .value_o (clipped),
        .sat_o   (clipped_flag)
    );

    always_comb begin
        state_d  = state_q;
        r_snap_d = r_snap_q;
        l_snap_d = l_snap_q;
        acc_d    = acc_q;
        step_d   = step_q;
        error_d  = error_q;
        sat_d    = sat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    r_snap_d = IR_R;
                    l_snap_d = IR_L;
                    acc_d    = '0;
                    step_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                acc_d  = acc_next;
                step_d = step_q + 1'b1;
                if (step_q == STEP_W'(LAST_STEP)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                error_d = clipped;
                sat_d   = clipped_flag;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r_snap_q <= '0;
            l_snap_q <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            error_q  <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_snap_q <= r_snap_d;
            l_snap_q <= l_snap_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            error_q  <= error_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign error = error_q;
    assign sat   = sat_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: doc/err_compute_seq.md
Name: err_compute_seq

Overview:
Parametrised, self-sequencing successor to the IR line-error datapath.
- On a start pulse it snapshots N_PAIRS right/left IR readings.
- It then accumulates the weighted difference sum((R_i - L_i) << i) serially, one operand per clock.
- It saturates the result to ERR_W signed bits and presents it to the PID block with a done pulse.
- This replaces the external accumulator control (clear, enable, subtract, select) with an internal FSM.

Parameters:
N_PAIRS  4   number of right/left sensor pairs; pair i carries weight 2^i (1..8)
IR_W     12  width of each unsigned IR reading
ERR_W    16  width of signed error output (>= 2)

Ports:
clk      input   1              system clock, 50MHz
rst_n    input   1              asynchronous active-low reset
start    input   1              request a new computation; sampled only in IDLE
IR_R     input   N_PAIRS*IR_W   right readings, inside out; reading i = IR_R[i*IR_W +: IR_W]
IR_L     input   N_PAIRS*IR_W   left readings, same packing
error    output  ERR_W signed   last completed, saturated error; held between completions
busy     output  1              high from the cycle after start is accepted until done
done     output  1              one-cycle pulse when error updates
sat      output  1              high when last result was clipped; updates with error

Behaviour:
- Reset (async, rst_n=0): state=IDLE; error=0, busy=0, done=0, sat=0; accumulator, step counter and snapshot registers cleared.
- Internal accumulator width ACC_W = IR_W + N_PAIRS + 1, signed.
  - The full sum never overflows internally.
  - Each operand is zero-extended, then shifted left by i.
- FSM states: IDLE, ACCUM, FINISH.
- IDLE:
  - On start=1, at the clock edge: snapshot IR_R/IR_L into registers, clear the accumulator, set step=0, go to ACCUM, busy=1.
  - On start=0: stay in IDLE.
- ACCUM, steps 0..2*N_PAIRS-1, one per clock:
  - Even step 2i: acc += R_i << i.
  - Odd step 2i+1: acc -= L_i << i, computed as two's complement (invert plus carry-in).
  - After the last step, go to FINISH.
- FINISH, one cycle, at the edge leaving it:
  - error = acc clipped to [-2^(ERR_W-1), 2^(ERR_W-1)-1].
  - sat = 1 if clipped, else 0.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge E0. done is high and error valid in the cycle after edge E0 + 2*N_PAIRS + 1 (9 edges at default). Throughput is one result per 2*N_PAIRS + 2 cycles.
- start while busy (ACCUM/FINISH) is ignored, not queued. start in the same cycle done is high is accepted, because the FSM is already in IDLE by then.
- IR inputs changing during ACCUM have no effect (snapshot).
- error and sat hold their values until the next FINISH; they are not cleared by start.
- Reset mid-computation aborts immediately and discards the partial result; error returns to 0.
- Identical readings on every pair give error=0, sat=0.

Decomposition:
- Package err_pkg:
  - err_state_t enum {IDLE, ACCUM, FINISH}.
  - Function acc_width(IR_W, N_PAIRS).
  - Function clog2-based step-counter width for 2*N_PAIRS.
- One sub-module, err_sat: parametrised combinational saturating narrow from ACC_W to ERR_W. It outputs the clipped value plus a sat flag, and is reusable by the PID block.

Test Plan:
- Reset: hold rst_n=0 mid-ACCUM -> error=0, busy=0, done=0, sat=0 immediately (asynchronous). After release, state is IDLE; the next start completes normally.
- Single weights: only R2=0x123 -> error=0x048C. Only L1=0x010 -> error=0xFFE0. Only R0=0x100 -> error=0x0100. In each case done goes high exactly 9 edges after start and sat=0.
- Saturation: all R=0xFFF, all L=0 -> raw sum 61425, error=0x7FFF, sat=1. Mirrored (all L=0xFFF, all R=0) -> error=0x8000, sat=1.
- Balance and snapshot: R=L=0x5A5 on all pairs -> error=0. Also randomise IR_R/IR_L every cycle during ACCUM after the snapshot -> result still equals the sum computed from the start-cycle values.
- Handshake: pulse start repeatedly while busy -> exactly one done, result from the first snapshot. start asserted in the done cycle -> second computation begins, back-to-back results 10 cycles apart.
- Parameter sweep: N_PAIRS=2, IR_W=8, ERR_W=10 with R1=0xFF, L0=0x01 -> raw 509, error=0x1FD, sat=0, done 5 edges after start.
